// File: rtl/dbe_ram_pkg.sv
// Request slice layout shared by all DBE RAM clients: {addr, wr_data, we, re}, re at the LSB.
package dbe_ram_pkg;

  localparam int RE_BIT    = 0;
  localparam int WE_BIT    = 1;
  localparam int WDATA_LSB = 2;

  function automatic int addr_lsb(input int data_w);
    return WDATA_LSB + data_w;
  endfunction

  function automatic int slice_w(input int addr_w, input int data_w);
    return addr_w + data_w + 2;
  endfunction

endpackage

// File: rtl/spram_xls_chan_mp_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last accepted grant; the pointer moves only on advance.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_grant_idx;

  // Walk from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    grant       = '0;
    w_idx       = '0;
    w_grant_idx = r_last;
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(r_last) + k) % N);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        w_grant_idx  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= IW'(N - 1);
    end else if (advance) begin
      r_last <= w_grant_idx;
    end
  end

endmodule

// File: rtl/spram_xls_chan_mp.sv
// Multi-channel single-port RAM: one request per cycle, round-robin granted, per-channel 1-deep
// read-response and write-completion buffers with independent ready/valid handshakes.
module spram_xls_chan_mp
  import dbe_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CH     = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH*(ADDR_WIDTH+DATA_WIDTH+2)-1:0]   req_data,
  input  logic [NUM_CH-1:0]                             req_vld,
  output logic [NUM_CH-1:0]                             req_rdy,
  output logic [NUM_CH*DATA_WIDTH-1:0]                  resp_data,
  output logic [NUM_CH-1:0]                             resp_vld,
  input  logic [NUM_CH-1:0]                             resp_rdy,
  output logic [NUM_CH-1:0]                             wr_comp_vld,
  input  logic [NUM_CH-1:0]                             wr_comp_rdy
);

  localparam int SW    = slice_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int AL    = addr_lsb(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_CH];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_CH];
  logic [NUM_CH-1:0]     w_re;
  logic [NUM_CH-1:0]     w_we;
  logic [NUM_CH-1:0]     w_resp_pop;
  logic [NUM_CH-1:0]     w_comp_pop;
  logic [NUM_CH-1:0]     w_elig;
  logic [NUM_CH-1:0]     w_grant;
  logic [NUM_CH-1:0]     w_load_resp;
  logic [NUM_CH-1:0]     w_set_comp;

  logic                  w_accept;
  logic                  w_sel_re;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  logic [NUM_CH-1:0]     r_resp_vld;
  logic [NUM_CH-1:0]     r_comp_vld;
  logic [NUM_CH-1:0]     r_fresh;
  logic [DATA_WIDTH-1:0] r_buf [NUM_CH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_re[gi]    = req_data[gi*SW + RE_BIT];
      assign w_we[gi]    = req_data[gi*SW + WE_BIT];
      assign w_wdata[gi] = req_data[gi*SW + WDATA_LSB +: DATA_WIDTH];
      assign w_addr[gi]  = req_data[gi*SW + AL +: ADDR_WIDTH];

      assign w_resp_pop[gi] = r_resp_vld[gi] & resp_rdy[gi];
      assign w_comp_pop[gi] = r_comp_vld[gi] & wr_comp_rdy[gi];

      // A full buffer only blocks the op that needs it, and only if it is not drained this cycle.
      assign w_elig[gi] = req_vld[gi]
                        & (~w_re[gi] | ~r_resp_vld[gi] | resp_rdy[gi])
                        & (~w_we[gi] | ~r_comp_vld[gi] | wr_comp_rdy[gi]);

      assign w_load_resp[gi] = w_accept & w_grant[gi] & w_re[gi];
      assign w_set_comp[gi]  = w_accept & w_grant[gi] & w_we[gi];

      // Fresh data lives in the RAM output register for one cycle, then is parked in r_buf.
      assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_fresh[gi] ? r_rd_data : r_buf[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_resp_vld[gi] <= 1'b0;
          r_comp_vld[gi] <= 1'b0;
          r_fresh[gi]    <= 1'b0;
          r_buf[gi]      <= '0;
        end else begin
          if (w_load_resp[gi]) begin
            r_resp_vld[gi] <= 1'b1;
          end else if (w_resp_pop[gi]) begin
            r_resp_vld[gi] <= 1'b0;
          end
          if (w_set_comp[gi]) begin
            r_comp_vld[gi] <= 1'b1;
          end else if (w_comp_pop[gi]) begin
            r_comp_vld[gi] <= 1'b0;
          end
          r_fresh[gi] <= w_load_resp[gi];
          if (r_fresh[gi]) begin
            r_buf[gi] <= r_rd_data;
          end
        end
      end
    end
  endgenerate

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_elig),
    .advance (w_accept),
    .grant   (w_grant)
  );

  assign w_accept    = (|w_grant) & ~rst;
  assign req_rdy     = w_grant & {NUM_CH{~rst}};
  assign resp_vld    = r_resp_vld;
  assign wr_comp_vld = r_comp_vld;

  always_comb begin
    w_sel_re    = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_sel_re    = w_re[i];
        w_sel_we    = w_we[i];
        w_sel_addr  = w_addr[i];
        w_sel_wdata = w_wdata[i];
      end
    end
  end

  // Read-first port: a combined read/write returns the pre-write word.
  always_ff @(posedge clk) begin
    if (w_accept && w_sel_we) begin
      r_mem[w_sel_addr] <= w_sel_wdata;
    end
    if (w_accept && w_sel_re) begin
      r_rd_data <= r_mem[w_sel_addr];
    end
  end

endmodule
